stq_addr_cam_p: RTL and testbench

//  Parametrised store-queue address CAM: DEPTH entries, each holding even/odd line addresses plus a lifecycle state.

---
 rtl/stq_addr_cam_p_if.sv | 53 +++++
 rtl/stq_addr_cam_p.sv | 155 +++++++++++++++
 tb/tb_stq_addr_cam_p.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stq_addr_cam_p_if.sv
// Store-queue CAM bus: AGU writes, load checks, lifecycle controls and allocator status.
// Mask signals exist only when STQ_CAM_BYTEMASK_EN is defined.
interface stq_addr_cam_p_if #(
  parameter int WIDTH     = 36,
  parameter int DEPTH     = 64,
  parameter int WRT_PORTS = 2,
  parameter int CHK_PORTS = 6,
  parameter int MASK_W    = 8
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                           excpt;
  logic [WRT_PORTS*DEPTH-1:0]     wrt_en;
  logic [WRT_PORTS*WIDTH-1:0]     wrt_addrE;
  logic [WRT_PORTS*WIDTH-1:0]     wrt_addrO;
  logic [CHK_PORTS-1:0]           chk_en;
  logic [CHK_PORTS*WIDTH-1:0]     chk_addrE;
  logic [CHK_PORTS*WIDTH-1:0]     chk_addrO;
  logic [CHK_PORTS*DEPTH*2-1:0]   chk_hit;
  logic [DEPTH-1:0]               upd_en;
  logic [DEPTH-1:0]               passe_en;
  logic [DEPTH-1:0]               free_en;
  logic [DEPTH-1:0]               free;
  logic [DEPTH-1:0]               upd;
  logic [DEPTH-1:0]               passe;
  logic [CNT_W-1:0]               free_cnt;
  logic                           full;
  logic                           empty;
`ifdef STQ_CAM_BYTEMASK_EN
  logic [WRT_PORTS*MASK_W-1:0]    wrt_maskE;
  logic [WRT_PORTS*MASK_W-1:0]    wrt_maskO;
  logic [CHK_PORTS*MASK_W-1:0]    chk_maskE;
  logic [CHK_PORTS*MASK_W-1:0]    chk_maskO;
`endif

  modport master (
`ifdef STQ_CAM_BYTEMASK_EN
    output wrt_maskE, wrt_maskO, chk_maskE, chk_maskO,
`endif
    output excpt, wrt_en, wrt_addrE, wrt_addrO, chk_en, chk_addrE, chk_addrO,
    output upd_en, passe_en, free_en,
    input  chk_hit, free, upd, passe, free_cnt, full, empty
  );

  modport slave (
`ifdef STQ_CAM_BYTEMASK_EN
    input  wrt_maskE, wrt_maskO, chk_maskE, chk_maskO,
`endif
    input  excpt, wrt_en, wrt_addrE, wrt_addrO, chk_en, chk_addrE, chk_addrO,
    input  upd_en, passe_en, free_en,
    output chk_hit, free, upd, passe, free_cnt, full, empty
  );
endinterface

// File: rtl/stq_addr_cam_p.sv
// Store-queue address CAM: per-entry even/odd line address + FREE/ADDR/DATA/PASSE lifecycle.
// Latency: chk_hit combinational; state and free_cnt/full/empty update on the edge. No backpressure.
// Optional byte-mask qualification of hits with STQ_CAM_BYTEMASK_EN.
module stq_addr_cam_p #(
  parameter int WIDTH     = 36,
  parameter int DEPTH     = 64,
  parameter int WRT_PORTS = 2,
  parameter int CHK_PORTS = 6,
  parameter int MASK_W    = 8
) (
  input  logic            clk,
  input  logic            rst,
  stq_addr_cam_p_if.slave bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    S_FREE  = 2'd0,
    S_ADDR  = 2'd1,
    S_DATA  = 2'd2,
    S_PASSE = 2'd3
  } st_t;

  st_t              st_q     [DEPTH];
  st_t              st_d     [DEPTH];
  logic [WIDTH-1:0] addr_e_q [DEPTH];
  logic [WIDTH-1:0] addr_o_q [DEPTH];
  logic [WIDTH-1:0] wr_e     [DEPTH];
  logic [WIDTH-1:0] wr_o     [DEPTH];
  logic [DEPTH-1:0] wr_any;
  logic [CNT_W-1:0] free_cnt_q;
  logic [CNT_W-1:0] free_cnt_d;
  logic             full_q;
  logic             empty_q;
`ifdef STQ_CAM_BYTEMASK_EN
  logic [MASK_W-1:0] mask_e_q [DEPTH];
  logic [MASK_W-1:0] mask_o_q [DEPTH];
  logic [MASK_W-1:0] wm_e     [DEPTH];
  logic [MASK_W-1:0] wm_o     [DEPTH];
`endif

  // Later ports overwrite earlier ones, so the highest-numbered writer wins.
  always_comb begin
    for (int e = 0; e < DEPTH; e++) begin
      wr_any[e] = 1'b0;
      wr_e[e]   = '0;
      wr_o[e]   = '0;
`ifdef STQ_CAM_BYTEMASK_EN
      wm_e[e]   = '0;
      wm_o[e]   = '0;
`endif
      for (int p = 0; p < WRT_PORTS; p++) begin
        if (bus.wrt_en[p*DEPTH+e]) begin
          wr_any[e] = 1'b1;
          wr_e[e]   = bus.wrt_addrE[p*WIDTH +: WIDTH];
          wr_o[e]   = bus.wrt_addrO[p*WIDTH +: WIDTH];
`ifdef STQ_CAM_BYTEMASK_EN
          wm_e[e]   = bus.wrt_maskE[p*MASK_W +: MASK_W];
          wm_o[e]   = bus.wrt_maskO[p*MASK_W +: MASK_W];
`endif
        end
      end
    end
  end

  // Retirement drain beats the flush; the flush blocks every younger event.
  always_comb begin
    for (int e = 0; e < DEPTH; e++) begin
      st_d[e] = st_q[e];
      if (bus.free_en[e] && st_q[e] == S_PASSE) begin
        st_d[e] = S_FREE;
      end else if (bus.excpt) begin
        if (st_q[e] == S_ADDR || st_q[e] == S_DATA) st_d[e] = S_FREE;
      end else if (bus.passe_en[e] && (st_q[e] == S_ADDR || st_q[e] == S_DATA)) begin
        st_d[e] = S_PASSE;
      end else if (bus.upd_en[e] && st_q[e] == S_ADDR) begin
        st_d[e] = S_DATA;
      end else if (wr_any[e] && st_q[e] == S_FREE) begin
        st_d[e] = S_ADDR;
      end
    end
  end

  always_comb begin
    free_cnt_d = '0;
    for (int e = 0; e < DEPTH; e++) begin
      if (st_d[e] == S_FREE) free_cnt_d = free_cnt_d + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int e = 0; e < DEPTH; e++) begin
        st_q[e]     <= S_FREE;
        addr_e_q[e] <= '0;
        addr_o_q[e] <= '0;
`ifdef STQ_CAM_BYTEMASK_EN
        mask_e_q[e] <= '0;
        mask_o_q[e] <= '0;
`endif
      end
      free_cnt_q <= CNT_W'(DEPTH);
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
    end else begin
      for (int e = 0; e < DEPTH; e++) begin
        st_q[e] <= st_d[e];
        if (wr_any[e] && !bus.excpt) begin
          addr_e_q[e] <= wr_e[e];
          addr_o_q[e] <= wr_o[e];
`ifdef STQ_CAM_BYTEMASK_EN
          mask_e_q[e] <= wm_e[e];
          mask_o_q[e] <= wm_o[e];
`endif
        end
      end
      free_cnt_q <= free_cnt_d;
      full_q     <= (free_cnt_d == '0);
      empty_q    <= (free_cnt_d == CNT_W'(DEPTH));
    end
  end

  // Only entries with an address but not yet retired can alias a younger load.
  always_comb begin
    bus.chk_hit = '0;
    for (int c = 0; c < CHK_PORTS; c++) begin
      for (int e = 0; e < DEPTH; e++) begin
        bus.chk_hit[(c*DEPTH+e)*2] = bus.chk_en[c]
            && (st_q[e] == S_ADDR || st_q[e] == S_DATA)
`ifdef STQ_CAM_BYTEMASK_EN
            && ((mask_e_q[e] & bus.chk_maskE[c*MASK_W +: MASK_W]) != '0)
`endif
            && (addr_e_q[e] == bus.chk_addrE[c*WIDTH +: WIDTH]);
        bus.chk_hit[(c*DEPTH+e)*2+1] = bus.chk_en[c]
            && (st_q[e] == S_ADDR || st_q[e] == S_DATA)
`ifdef STQ_CAM_BYTEMASK_EN
            && ((mask_o_q[e] & bus.chk_maskO[c*MASK_W +: MASK_W]) != '0)
`endif
            && (addr_o_q[e] == bus.chk_addrO[c*WIDTH +: WIDTH]);
      end
    end
  end

  always_comb begin
    for (int e = 0; e < DEPTH; e++) begin
      bus.free[e]  = (st_q[e] == S_FREE);
      bus.upd[e]   = (st_q[e] == S_DATA);
      bus.passe[e] = (st_q[e] == S_PASSE);
    end
  end

  assign bus.free_cnt = free_cnt_q;
  assign bus.full     = full_q;
  assign bus.empty    = empty_q;
endmodule

// File: tb/tb_stq_addr_cam_p.sv
// Directed and randomized checks of stq_addr_cam_p against an array-based lifecycle model.
module tb_stq_addr_cam_p;
  localparam int W  = 36;
  localparam int D  = 64;
  localparam int WP = 2;
  localparam int CP = 6;
  localparam int MW = 8;
  localparam int HB = CP*D*2;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  // Lifecycle codes as named in the block description.
  localparam int FREE = 0, ADDR = 1, DATA = 2, PASSE = 3;
  int           m_st [D];
  logic [W-1:0] m_ae [D];
  logic [W-1:0] m_ao [D];
  logic [MW-1:0] m_me [D];
  logic [MW-1:0] m_mo [D];

  stq_addr_cam_p_if #(.WIDTH(W), .DEPTH(D), .WRT_PORTS(WP), .CHK_PORTS(CP), .MASK_W(MW)) bus ();

  stq_addr_cam_p #(.WIDTH(W), .DEPTH(D), .WRT_PORTS(WP), .CHK_PORTS(CP), .MASK_W(MW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string tag, input logic [HB-1:0] obs, input logic [HB-1:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int e = 0; e < D; e++) begin
      m_st[e] = FREE; m_ae[e] = '0; m_ao[e] = '0; m_me[e] = '0; m_mo[e] = '0;
    end
  endtask

  function automatic logic [D-1:0] vec_of(input int s);
    logic [D-1:0] v = '0;
    for (int e = 0; e < D; e++) v[e] = (m_st[e] == s);
    return v;
  endfunction

  function automatic int n_free();
    int n = 0;
    for (int e = 0; e < D; e++) if (m_st[e] == FREE) n++;
    return n;
  endfunction

  function automatic logic [HB-1:0] exp_hit();
    logic [HB-1:0] r = '0;
    for (int c = 0; c < CP; c++) begin
      for (int e = 0; e < D; e++) begin
        if (bus.chk_en[c] && (m_st[e] == ADDR || m_st[e] == DATA)) begin
          logic me_ok = 1'b1;
          logic mo_ok = 1'b1;
`ifdef STQ_CAM_BYTEMASK_EN
          me_ok = (m_me[e] & bus.chk_maskE[c*MW +: MW]) != 0;
          mo_ok = (m_mo[e] & bus.chk_maskO[c*MW +: MW]) != 0;
`endif
          if (me_ok && m_ae[e] == bus.chk_addrE[c*W +: W]) r[(c*D+e)*2]   = 1'b1;
          if (mo_ok && m_ao[e] == bus.chk_addrO[c*W +: W]) r[(c*D+e)*2+1] = 1'b1;
        end
      end
    end
    return r;
  endfunction

  task automatic check_all(input string tag);
    int nf = n_free();
    cmp({tag, "_free"},  HB'(bus.free),     HB'(vec_of(FREE)));
    cmp({tag, "_upd"},   HB'(bus.upd),      HB'(vec_of(DATA)));
    cmp({tag, "_passe"}, HB'(bus.passe),    HB'(vec_of(PASSE)));
    cmp({tag, "_cnt"},   HB'(bus.free_cnt), HB'(nf));
    cmp({tag, "_full"},  HB'(bus.full),     HB'(nf == 0));
    cmp({tag, "_empty"}, HB'(bus.empty),    HB'(nf == D));
    cmp({tag, "_hit"},   bus.chk_hit,       exp_hit());
  endtask

  task automatic clear_ctrl();
    bus.excpt = 1'b0; bus.wrt_en = '0; bus.wrt_addrE = '0; bus.wrt_addrO = '0;
    bus.upd_en = '0; bus.passe_en = '0; bus.free_en = '0;
`ifdef STQ_CAM_BYTEMASK_EN
    bus.wrt_maskE = '0; bus.wrt_maskO = '0;
`endif
  endtask

  task automatic clear_chk();
    bus.chk_en = '0; bus.chk_addrE = '0; bus.chk_addrO = '0;
`ifdef STQ_CAM_BYTEMASK_EN
    bus.chk_maskE = '1; bus.chk_maskO = '1;
`endif
  endtask

  // Apply the lifecycle rules to the model with the inputs present before the edge, then clock.
  task automatic tick();
    int            n_st [D];
    logic [W-1:0]  n_ae [D];
    logic [W-1:0]  n_ao [D];
    logic [MW-1:0] n_me [D];
    logic [MW-1:0] n_mo [D];
    for (int e = 0; e < D; e++) begin
      int w = -1;
      for (int p = 0; p < WP; p++) if (bus.wrt_en[p*D+e]) w = p;
      n_st[e] = m_st[e]; n_ae[e] = m_ae[e]; n_ao[e] = m_ao[e]; n_me[e] = m_me[e]; n_mo[e] = m_mo[e];
      case (m_st[e])
        PASSE: if (bus.free_en[e]) n_st[e] = FREE;
        ADDR:  if (bus.excpt) n_st[e] = FREE;
               else if (bus.passe_en[e]) n_st[e] = PASSE;
               else if (bus.upd_en[e]) n_st[e] = DATA;
        DATA:  if (bus.excpt) n_st[e] = FREE;
               else if (bus.passe_en[e]) n_st[e] = PASSE;
        default: if (!bus.excpt && w >= 0) n_st[e] = ADDR;
      endcase
      if (w >= 0 && !bus.excpt) begin
        n_ae[e] = bus.wrt_addrE[w*W +: W];
        n_ao[e] = bus.wrt_addrO[w*W +: W];
`ifdef STQ_CAM_BYTEMASK_EN
        n_me[e] = bus.wrt_maskE[w*MW +: MW];
        n_mo[e] = bus.wrt_maskO[w*MW +: MW];
`endif
      end
    end
    @(posedge clk);
    for (int e = 0; e < D; e++) begin
      m_st[e] = n_st[e]; m_ae[e] = n_ae[e]; m_ao[e] = n_ao[e]; m_me[e] = n_me[e]; m_mo[e] = n_mo[e];
    end
    #1;
    clear_ctrl();
  endtask

  task automatic wr(input int p, input int e, input logic [W-1:0] ae, input logic [W-1:0] ao);
    bus.wrt_en[p*D+e] = 1'b1;
    bus.wrt_addrE[p*W +: W] = ae;
    bus.wrt_addrO[p*W +: W] = ao;
`ifdef STQ_CAM_BYTEMASK_EN
    bus.wrt_maskE[p*MW +: MW] = 8'hFF;
    bus.wrt_maskO[p*MW +: MW] = 8'hFF;
`endif
  endtask

  function automatic logic [D-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  initial begin
    rst = 1'b1;
    clear_ctrl();
    clear_chk();
    model_reset();
    #12;
    check_all("reset");
    cmp("reset_cnt64", HB'(bus.free_cnt), HB'(64));
    rst = 1'b0;

    // Single write then a matching lookup on port 2.
    wr(0, 5, 36'h123, 36'h0);
    tick();
    check_all("wr5");
    cmp("wr5_cnt", HB'(bus.free_cnt), HB'(63));
    bus.chk_en[2] = 1'b1;
    bus.chk_addrE[2*W +: W] = 36'h123;
    bus.chk_addrO[2*W +: W] = 36'h777;
    #1;
    check_all("chk5");
    cmp("chk5_bit", HB'(bus.chk_hit[(2*D+5)*2]), HB'(1));

    // Lifecycle of entry 5.
    bus.upd_en[5] = 1'b1;  tick(); check_all("upd5");
    cmp("upd5_bit", HB'(bus.upd[5]), HB'(1));
    bus.passe_en[5] = 1'b1; tick(); check_all("passe5");
    cmp("passe5_nohit", HB'(bus.chk_hit[(2*D+5)*2]), HB'(0));
    bus.free_en[5] = 1'b1; tick(); check_all("free5");
    cmp("free5_cnt", HB'(bus.free_cnt), HB'(64));
    clear_chk();

    // Flush keeps retired entries.
    wr(0, 1, 36'h10, 36'h11); wr(1, 2, 36'h20, 36'h21); tick();
    wr(0, 3, 36'h30, 36'h31); tick();
    bus.upd_en[1] = 1'b1; bus.upd_en[2] = 1'b1; bus.upd_en[3] = 1'b1; tick();
    bus.passe_en[3] = 1'b1; tick(); check_all("pre_excpt");
    bus.excpt = 1'b1; bus.passe_en[1] = 1'b1; wr(0, 7, 36'h70, 36'h71); tick();
    check_all("excpt");
    cmp("excpt_cnt", HB'(bus.free_cnt), HB'(63));
    cmp("excpt_keep3", HB'(bus.passe[3]), HB'(1));
    bus.free_en[3] = 1'b1; tick();

    // Same-entry collision: port 1 wins.
    wr(0, 9, 36'hA, 36'h1); wr(1, 9, 36'hB, 36'h2); tick();
    bus.chk_en[0] = 1'b1; bus.chk_addrE[0 +: W] = 36'hB; bus.chk_addrO[0 +: W] = 36'h2;
    bus.chk_en[1] = 1'b1; bus.chk_addrE[W +: W] = 36'hA; bus.chk_addrO[W +: W] = 36'h1;
    #1;
    check_all("collide");
    cmp("collide_B", HB'(bus.chk_hit[(0*D+9)*2 +: 2]), HB'(2'b11));
    cmp("collide_A", HB'(bus.chk_hit[(1*D+9)*2 +: 2]), HB'(2'b00));
    clear_chk();

    // Fill every entry, then drain with a flush.
    for (int k = 0; k < D/2; k++) begin
      wr(0, 2*k, W'(k), W'(k+100)); wr(1, 2*k+1, W'(k+200), W'(k+300)); tick();
    end
    check_all("fill");
    cmp("fill_full", HB'(bus.full), HB'(1));
    cmp("fill_cnt0", HB'(bus.free_cnt), HB'(0));
    bus.excpt = 1'b1; tick();
    check_all("drain");
    cmp("drain_empty", HB'(bus.empty), HB'(1));

`ifdef STQ_CAM_BYTEMASK_EN
    wr(0, 20, 36'h55, 36'h66);
    bus.wrt_maskE[0 +: MW] = 8'h0F;
    tick();
    bus.chk_en[0] = 1'b1; bus.chk_addrE[0 +: W] = 36'h55; bus.chk_maskE[0 +: MW] = 8'hF0;
    #1;
    check_all("mask_miss");
    cmp("mask_miss_bit", HB'(bus.chk_hit[(0*D+20)*2]), HB'(0));
    bus.chk_maskE[0 +: MW] = 8'h18;
    #1;
    check_all("mask_hit");
    cmp("mask_hit_bit", HB'(bus.chk_hit[(0*D+20)*2]), HB'(1));
    clear_chk();
`endif

    // Randomized traffic over a small address pool so hits are frequent.
    for (int i = 0; i < 400; i++) begin
      for (int p = 0; p < WP; p++) begin
        if ($urandom_range(0, 3) != 0) begin
          bus.wrt_en[p*D + $urandom_range(0, D-1)] = 1'b1;
          bus.wrt_addrE[p*W +: W] = W'($urandom_range(0, 3));
          bus.wrt_addrO[p*W +: W] = W'($urandom_range(0, 3));
`ifdef STQ_CAM_BYTEMASK_EN
          bus.wrt_maskE[p*MW +: MW] = MW'($urandom);
          bus.wrt_maskO[p*MW +: MW] = MW'($urandom);
`endif
        end
      end
      if ($urandom_range(0, 1) == 0) bus.wrt_en[$urandom_range(0, D-1)] = 1'b1;
      bus.upd_en   = rnd64() & rnd64();
      bus.passe_en = rnd64() & rnd64() & rnd64();
      bus.free_en  = rnd64() & rnd64() & rnd64();
      bus.excpt    = ($urandom_range(0, 24) == 0);
      tick();
      for (int c = 0; c < CP; c++) begin
        bus.chk_en[c] = 1'($urandom_range(0, 3) != 0);
        bus.chk_addrE[c*W +: W] = W'($urandom_range(0, 3));
        bus.chk_addrO[c*W +: W] = W'($urandom_range(0, 3));
`ifdef STQ_CAM_BYTEMASK_EN
        bus.chk_maskE[c*MW +: MW] = MW'($urandom);
        bus.chk_maskO[c*MW +: MW] = MW'($urandom);
`endif
      end
      #1;
      check_all($sformatf("rnd%0d", i));
    end

    // Asynchronous reset asserted away from any clock edge.
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_all("async_rst");
    @(negedge clk);
    rst = 1'b0;
    wr(1, 63, 36'hFFFFFFFFF, 36'h0);
    tick();
    check_all("post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
